// File: rtl/mapper_pkg.sv
// mapper_pkg: mode encodings and write-FSM states shared by the discrete mapper files
package mapper_pkg;
  typedef enum logic [1:0] {
    MODE_UNROM = 2'd0,
    MODE_CNROM = 2'd1,
    MODE_AOROM = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    COMMIT = 2'd2
  } state_e;
  function automatic mode_e eff_mode(input logic [1:0] m);
    return (mode_e'(m) == MODE_RSVD) ? MODE_UNROM : mode_e'(m);
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser with a glitch-free rising-edge pulse taken from settled flops
module sync_edge_det (
  input  logic clk,
  input  logic Nrst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge Nrst)
    if (!Nrst) s <= '1;
    else s <= {s[1:0], d};
  assign q = s[1];
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/discrete_mapper_reg.sv
// discrete_mapper_reg: UNROM/CNROM/AOROM bank register with synchronised CPU write capture
module discrete_mapper_reg
  import mapper_pkg::*;
#(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 2,
  parameter int BUS_CONFLICT  = 1
) (
  input  logic                     clk,
  input  logic                     Nrst,
  input  logic [7:0]               cpu_d,
  input  logic [7:0]               rom_d,
  input  logic                     cpu_a14,
  input  logic                     Ncpu_rw,
  input  logic                     Ncpu_rom_cs,
  input  logic [1:0]               mode,
  input  logic                     hv_mirror,
  input  logic                     ppu_a10,
  input  logic                     ppu_a11,
  output logic [PRG_BANK_BITS-1:0] prg_a,
  output logic [CHR_BANK_BITS-1:0] chr_a,
  output logic                     ciram_a10
);
  logic cs_s, cs_rise, rw_s, rw_rise_unused;
  logic cap, mode_chg;
  logic [1:0] mode_q;
  logic [7:0] wr_data;
  logic [PRG_BANK_BITS-1:0] prg_reg;
  logic [CHR_BANK_BITS-1:0] chr_reg;
  logic mir_reg;
  mode_e eff;
  state_e state_q, state_d;
  sync_edge_det u_cs (.clk(clk), .Nrst(Nrst), .d(Ncpu_rom_cs), .q(cs_s), .rise(cs_rise));
  sync_edge_det u_rw (.clk(clk), .Nrst(Nrst), .d(Ncpu_rw), .q(rw_s), .rise(rw_rise_unused));
  assign eff = eff_mode(mode);
  assign mode_chg = mode != mode_q;
  always_comb begin
    state_d = state_q;
    cap = 1'b0;
    case (state_q)
      IDLE: begin
        cap = !cs_s && !rw_s;
        state_d = cap ? ACCESS : IDLE;
      end
      ACCESS: begin
        cap = !cs_s && !rw_s;
        state_d = cs_rise ? COMMIT : (rw_s ? IDLE : ACCESS);
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Nrst)
    if (!Nrst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      wr_data <= '0;
      prg_reg <= '0;
      chr_reg <= '0;
      mir_reg <= 1'b0;
    end else begin
      mode_q  <= mode;
      state_q <= mode_chg ? IDLE : state_d;
      if (cap) wr_data <= (BUS_CONFLICT != 0) ? (cpu_d & rom_d) : cpu_d;
      if (mode_chg) begin
        prg_reg <= '0;
        chr_reg <= '0;
        mir_reg <= 1'b0;
      end else if (state_q == COMMIT) begin
        if (eff == MODE_CNROM) chr_reg <= wr_data[CHR_BANK_BITS-1:0];
        else if (eff == MODE_AOROM) begin
          prg_reg <= {1'b0, wr_data[PRG_BANK_BITS-2:0]};
          mir_reg <= wr_data[4];
        end else prg_reg <= wr_data[PRG_BANK_BITS-1:0];
      end
    end
  assign prg_a = (eff == MODE_CNROM) ? {{(PRG_BANK_BITS-1){1'b1}}, cpu_a14} :
                 (eff == MODE_AOROM) ? {prg_reg[PRG_BANK_BITS-2:0], cpu_a14} :
                 cpu_a14 ? '1 : prg_reg;
  assign chr_a = (eff == MODE_CNROM) ? chr_reg : '0;
  assign ciram_a10 = (eff == MODE_AOROM) ? mir_reg : (hv_mirror ? ppu_a10 : ppu_a11);
endmodule

// File: tb/tb_discrete_mapper_reg.sv
// tb_discrete_mapper_reg: directed checks of the mapper register with and without bus conflicts
module tb_discrete_mapper_reg;
  logic clk = 1'b0;
  logic Nrst = 1'b0;
  logic [7:0] cpu_d = '0, rom_d = '1;
  logic cpu_a14 = 1'b0, Ncpu_rw = 1'b1, Ncpu_rom_cs = 1'b1;
  logic [1:0] mode = 2'd0;
  logic hv_mirror = 1'b1, ppu_a10 = 1'b0, ppu_a11 = 1'b0;
  logic [3:0] prg_a, prg_a_nc;
  logic [1:0] chr_a, chr_a_nc;
  logic ciram_a10, ciram_a10_nc;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  discrete_mapper_reg #(.PRG_BANK_BITS(4), .CHR_BANK_BITS(2), .BUS_CONFLICT(1)) dut (
    .clk(clk), .Nrst(Nrst), .cpu_d(cpu_d), .rom_d(rom_d), .cpu_a14(cpu_a14),
    .Ncpu_rw(Ncpu_rw), .Ncpu_rom_cs(Ncpu_rom_cs), .mode(mode), .hv_mirror(hv_mirror),
    .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .prg_a(prg_a), .chr_a(chr_a), .ciram_a10(ciram_a10));

  discrete_mapper_reg #(.PRG_BANK_BITS(4), .CHR_BANK_BITS(2), .BUS_CONFLICT(0)) dut_nc (
    .clk(clk), .Nrst(Nrst), .cpu_d(cpu_d), .rom_d(rom_d), .cpu_a14(cpu_a14),
    .Ncpu_rw(Ncpu_rw), .Ncpu_rom_cs(Ncpu_rom_cs), .mode(mode), .hv_mirror(hv_mirror),
    .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .prg_a(prg_a_nc), .chr_a(chr_a_nc), .ciram_a10(ciram_a10_nc));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full CPU write; returns exactly 4 negedges after the raw cs rise.
  task automatic bus_write(input logic [7:0] d, input logic [7:0] r);
    @(negedge clk);
    cpu_d = d; rom_d = r; Ncpu_rw = 1'b0; Ncpu_rom_cs = 1'b0;
    wait_clk(4);
    Ncpu_rom_cs = 1'b1;
    wait_clk(4);
    Ncpu_rw = 1'b1;
  endtask

  task automatic bus_read(input logic [7:0] d);
    @(negedge clk);
    cpu_d = d; Ncpu_rw = 1'b1; Ncpu_rom_cs = 1'b0;
    wait_clk(4);
    Ncpu_rom_cs = 1'b1;
    wait_clk(6);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    wait_clk(2);
  endtask

  initial begin
    wait_clk(3);
    cpu_a14 = 1'b0; #1;
    check("reset_prg_lo", {4'd0, prg_a}, 8'd0);
    Nrst = 1'b1;
    wait_clk(2);
    check("post_reset_prg_lo", {4'd0, prg_a}, 8'd0);
    cpu_a14 = 1'b1; #1;
    check("post_reset_prg_hi", {4'd0, prg_a}, 8'd15);
    check("post_reset_chr", {6'd0, chr_a}, 8'd0);
    hv_mirror = 1'b1; ppu_a10 = 1'b1; ppu_a11 = 1'b0; #1;
    check("mirror_vert", {7'd0, ciram_a10}, 8'd1);
    hv_mirror = 1'b0; #1;
    check("mirror_horiz", {7'd0, ciram_a10}, 8'd0);

    bus_write(8'h05, 8'hFF);
    cpu_a14 = 1'b0; #1;
    check("unrom_w05_lo", {4'd0, prg_a}, 8'd5);
    cpu_a14 = 1'b1; #1;
    check("unrom_w05_hi", {4'd0, prg_a}, 8'd15);
    check("unrom_chr", {6'd0, chr_a}, 8'd0);

    bus_write(8'h07, 8'h03);
    cpu_a14 = 1'b0; #1;
    check("conflict_and", {4'd0, prg_a}, 8'd3);
    check("no_conflict", {4'd0, prg_a_nc}, 8'd7);

    bus_read(8'h0A);
    check("read_no_change", {4'd0, prg_a}, 8'd3);

    // rw rises while cs stays low: the write must be abandoned
    @(negedge clk);
    cpu_d = 8'h09; rom_d = 8'hFF; Ncpu_rw = 1'b0; Ncpu_rom_cs = 1'b0;
    wait_clk(3);
    Ncpu_rw = 1'b1;
    wait_clk(3);
    Ncpu_rom_cs = 1'b1;
    wait_clk(6);
    check("rw_abort", {4'd0, prg_a}, 8'd3);

    // one-clock cs glitch: old value or the complete new one
    @(negedge clk);
    cpu_d = 8'h0C; rom_d = 8'hFF; Ncpu_rw = 1'b0; Ncpu_rom_cs = 1'b0;
    @(negedge clk);
    Ncpu_rom_cs = 1'b1;
    wait_clk(8);
    Ncpu_rw = 1'b1;
    n_chk++;
    assert (prg_a === 4'd3 || prg_a === 4'd12) else begin
      n_fail++;
      $error("FAIL cs_glitch: observed %0d expected 3 or 12", prg_a);
    end

    // reset in the middle of a write
    @(negedge clk);
    cpu_d = 8'h09; rom_d = 8'hFF; Ncpu_rw = 1'b0; Ncpu_rom_cs = 1'b0;
    wait_clk(3);
    Nrst = 1'b0; #1;
    check("reset_mid_write_in", {4'd0, prg_a}, 8'd0);
    wait_clk(1);
    Ncpu_rom_cs = 1'b1; Ncpu_rw = 1'b1;
    wait_clk(2);
    Nrst = 1'b1;
    wait_clk(6);
    check("reset_mid_write_out", {4'd0, prg_a}, 8'd0);

    set_mode(2'd1);
    bus_write(8'h02, 8'hFF);
    check("cnrom_chr", {6'd0, chr_a}, 8'd2);
    cpu_a14 = 1'b0; #1;
    check("cnrom_prg_lo", {4'd0, prg_a}, 8'd14);
    cpu_a14 = 1'b1; #1;
    check("cnrom_prg_hi", {4'd0, prg_a}, 8'd15);
    bus_read(8'h01);
    check("cnrom_read_keep", {6'd0, chr_a}, 8'd2);

    set_mode(2'd2);
    bus_write(8'h13, 8'hFF);
    cpu_a14 = 1'b0; #1;
    check("aorom_prg_lo", {4'd0, prg_a}, 8'd6);
    cpu_a14 = 1'b1; #1;
    check("aorom_prg_hi", {4'd0, prg_a}, 8'd7);
    check("aorom_chr", {6'd0, chr_a}, 8'd0);
    hv_mirror = 1'b1; ppu_a10 = 1'b0; ppu_a11 = 1'b0; #1;
    check("aorom_mir_00", {7'd0, ciram_a10}, 8'd1);
    hv_mirror = 1'b0; ppu_a11 = 1'b0; ppu_a10 = 1'b1; #1;
    check("aorom_mir_10", {7'd0, ciram_a10}, 8'd1);

    set_mode(2'd0);
    bus_write(8'h05, 8'hFF);
    cpu_a14 = 1'b0; #1;
    check("pre_switch_prg", {4'd0, prg_a}, 8'd5);
    set_mode(2'd2);
    check("switch_aorom_prg", {4'd0, prg_a}, 8'd0);
    check("switch_aorom_mir", {7'd0, ciram_a10}, 8'd0);
    set_mode(2'd0);
    check("switch_back_prg", {4'd0, prg_a}, 8'd0);

    set_mode(2'd3);
    bus_write(8'h06, 8'hFF);
    check("rsvd_as_unrom", {4'd0, prg_a}, 8'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
